dispatch_nw: RTL and testbench

N-wide, in-order dispatch stage with a one-group holding register. It sits between the Rename output register and the backend structures: ALU_RS, MDU_RS, LSQ and ROB. Each cycle it dispatches the longest in-order prefix of held instructions that fits the free capacity of the target queues and the ROB. Undispatched instructions stay held, so partial groups drain over several cycles. Per-cause stall counters are provided for performance analysis.

---
 rtl/dispatch_nw_pkg.sv | 29 ++
 rtl/dispatch_nw_if.sv | 40 ++++
 rtl/dispatch_nw_pack.sv | 33 +++
 rtl/dispatch_nw.sv | 163 ++++++++++++++++
 tb/tb_dispatch_nw.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dispatch_nw_pkg.sv
// Shared types for the N-wide dispatch stage: renamed instruction format,
// dispatch target classes and the classification rule.
package dispatch_nw_pkg;

  typedef struct packed {
    logic       is_valid;
    logic       is_load;
    logic       is_store;
    logic       is_muldiv;
    logic [5:0] pdst;
    logic [5:0] psrc1;
    logic [5:0] psrc2;
    logic [6:0] rob_idx;
  } renamed_inst_t;

  typedef enum logic [1:0] {
    DISP_ALU,
    DISP_MDU,
    DISP_LSQ
  } disp_target_e;

  // Memory ops win over muldiv when both flags are set.
  function automatic disp_target_e classify(input renamed_inst_t inst);
    if (inst.is_load || inst.is_store) return DISP_LSQ;
    if (inst.is_muldiv) return DISP_MDU;
    return DISP_ALU;
  endfunction

endpackage

// File: rtl/dispatch_nw_if.sv
// Rename-side group handshake plus backend free counts and write ports.
// Handshake: a group moves on a rising edge where in_valid && dispatch_rdy.
interface dispatch_nw_if
  import dispatch_nw_pkg::*;
#(
  parameter int N      = 2,
  parameter int FREE_W = $clog2(N + 1)
);
  logic                     in_valid;
  renamed_inst_t [N-1:0]    in_inst;
  logic                     dispatch_rdy;

  logic [FREE_W-1:0]        alu_free;
  logic [FREE_W-1:0]        mdu_free;
  logic [FREE_W-1:0]        lsq_free;
  logic [FREE_W-1:0]        rob_free;

  logic [N-1:0]             alu_rs_we;
  logic [N-1:0]             mdu_rs_we;
  logic [N-1:0]             lsq_rs_we;
  logic [N-1:0]             rob_we;
  renamed_inst_t [N-1:0]    alu_rs_entry;
  renamed_inst_t [N-1:0]    mdu_rs_entry;
  renamed_inst_t [N-1:0]    lsq_rs_entry;
  renamed_inst_t [N-1:0]    rob_entry;

  modport slave (
    input  in_valid, in_inst, alu_free, mdu_free, lsq_free, rob_free,
    output dispatch_rdy,
    output alu_rs_we, mdu_rs_we, lsq_rs_we, rob_we,
    output alu_rs_entry, mdu_rs_entry, lsq_rs_entry, rob_entry
  );

  modport master (
    output in_valid, in_inst, alu_free, mdu_free, lsq_free, rob_free,
    input  dispatch_rdy,
    input  alu_rs_we, mdu_rs_we, lsq_rs_we, rob_we,
    input  alu_rs_entry, mdu_rs_entry, lsq_rs_entry, rob_entry
  );
endinterface

// File: rtl/dispatch_nw_pack.sv
// Per-queue compactor: moves enabled entries down to the low slots,
// preserving program order, and raises a contiguous we mask from bit 0.
module dispatch_nw_pack
  import dispatch_nw_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]          en_i,
  input  renamed_inst_t [N-1:0] ent_i,
  output logic [N-1:0]          we_o,
  output renamed_inst_t [N-1:0] ent_o
);

  always_comb begin : pack
    int cnt;
    we_o  = '0;
    ent_o = '0;
    cnt   = 0;
    for (int j = 0; j < N; j++) begin
      cnt = 0;
      for (int i = 0; i < N; i++) begin
        if (en_i[i]) begin
          if (cnt == j) begin
            we_o[j]  = 1'b1;
            ent_o[j] = ent_i[i];
          end
          cnt = cnt + 1;
        end
      end
    end
  end

endmodule

// File: rtl/dispatch_nw.sv
// N-wide in-order dispatch with a one-group holding register, prefix
// eligibility against queue/ROB free counts, and per-cause stall counters.
module dispatch_nw
  import dispatch_nw_pkg::*;
#(
  parameter int DISPATCH_WIDTH = 2,
  parameter int FREE_W         = $clog2(DISPATCH_WIDTH + 1),
  parameter int PERF_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  dispatch_nw_if.slave      io,
  output logic [PERF_W-1:0] stall_alu_cnt,
  output logic [PERF_W-1:0] stall_mdu_cnt,
  output logic [PERF_W-1:0] stall_lsq_cnt,
  output logic [PERF_W-1:0] stall_rob_cnt
);

  localparam int N = DISPATCH_WIDTH;
  localparam logic [FREE_W-1:0] ONE = FREE_W'(1);

  renamed_inst_t [N-1:0] hold_inst_q, hold_inst_d;
  logic [N-1:0]          hold_vld_q, hold_vld_d;
  logic [PERF_W-1:0]     stall_alu_q, stall_alu_d;
  logic [PERF_W-1:0]     stall_mdu_q, stall_mdu_d;
  logic [PERF_W-1:0]     stall_lsq_q, stall_lsq_d;
  logic [PERF_W-1:0]     stall_rob_q, stall_rob_d;

  logic [N-1:0]      go, is_alu, is_mdu, is_lsq;
  logic [N-1:0]      alu_en, mdu_en, lsq_en, rob_en;
  logic [FREE_W-1:0] alu_used, mdu_used, lsq_used, rob_used, q_free, q_used;
  logic              blocked, all_go;
  logic              inc_alu, inc_mdu, inc_lsq, inc_rob;
  disp_target_e      tgt;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v,
                                                 input logic en);
    return (en && (v != '1)) ? v + PERF_W'(1) : v;
  endfunction

  always_comb begin : eligibility
    go       = '0;
    is_alu   = '0;
    is_mdu   = '0;
    is_lsq   = '0;
    alu_used = '0;
    mdu_used = '0;
    lsq_used = '0;
    rob_used = '0;
    q_free   = '0;
    q_used   = '0;
    tgt      = DISP_ALU;
    blocked  = 1'b0;
    inc_alu  = 1'b0;
    inc_mdu  = 1'b0;
    inc_lsq  = 1'b0;
    inc_rob  = 1'b0;
    for (int i = 0; i < N; i++) begin
      tgt       = classify(hold_inst_q[i]);
      is_alu[i] = (tgt == DISP_ALU);
      is_mdu[i] = (tgt == DISP_MDU);
      is_lsq[i] = (tgt == DISP_LSQ);
      case (tgt)
        DISP_MDU: begin q_free = io.mdu_free; q_used = mdu_used; end
        DISP_LSQ: begin q_free = io.lsq_free; q_used = lsq_used; end
        default:  begin q_free = io.alu_free; q_used = alu_used; end
      endcase
      // Bubbles and already-dispatched slots neither consume nor block.
      if (hold_vld_q[i] && !blocked) begin
        if ((io.rob_free > rob_used) && (q_free > q_used)) begin
          go[i]    = 1'b1;
          rob_used = rob_used + ONE;
          case (tgt)
            DISP_MDU: mdu_used = mdu_used + ONE;
            DISP_LSQ: lsq_used = lsq_used + ONE;
            default:  alu_used = alu_used + ONE;
          endcase
        end else begin
          blocked = 1'b1;
          if (io.rob_free <= rob_used) inc_rob = 1'b1;
          else begin
            case (tgt)
              DISP_MDU: inc_mdu = 1'b1;
              DISP_LSQ: inc_lsq = 1'b1;
              default:  inc_alu = 1'b1;
            endcase
          end
        end
      end
    end
    all_go = &(go | ~hold_vld_q);
    rob_en = flush ? '0 : go;
    alu_en = flush ? '0 : (go & is_alu);
    mdu_en = flush ? '0 : (go & is_mdu);
    lsq_en = flush ? '0 : (go & is_lsq);
  end

  always_comb begin : next_state
    hold_inst_d = hold_inst_q;
    hold_vld_d  = hold_vld_q & ~go;
    if (flush) begin
      hold_vld_d = '0;
    end else if (all_go) begin
      if (io.in_valid) begin
        hold_inst_d = io.in_inst;
        for (int i = 0; i < N; i++) hold_vld_d[i] = io.in_inst[i].is_valid;
      end else begin
        hold_vld_d = '0;
      end
    end
    stall_alu_d = sat_inc(stall_alu_q, inc_alu && !flush);
    stall_mdu_d = sat_inc(stall_mdu_q, inc_mdu && !flush);
    stall_lsq_d = sat_inc(stall_lsq_q, inc_lsq && !flush);
    stall_rob_d = sat_inc(stall_rob_q, inc_rob && !flush);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_inst_q <= '0;
      hold_vld_q  <= '0;
      stall_alu_q <= '0;
      stall_mdu_q <= '0;
      stall_lsq_q <= '0;
      stall_rob_q <= '0;
    end else begin
      hold_inst_q <= hold_inst_d;
      hold_vld_q  <= hold_vld_d;
      stall_alu_q <= stall_alu_d;
      stall_mdu_q <= stall_mdu_d;
      stall_lsq_q <= stall_lsq_d;
      stall_rob_q <= stall_rob_d;
    end
  end

  logic [N-1:0]          alu_we, mdu_we, lsq_we, rob_we;
  renamed_inst_t [N-1:0] alu_ent, mdu_ent, lsq_ent, rob_ent;

  dispatch_nw_pack #(.N(N)) u_pack_alu (
    .en_i(alu_en), .ent_i(hold_inst_q), .we_o(alu_we), .ent_o(alu_ent));
  dispatch_nw_pack #(.N(N)) u_pack_mdu (
    .en_i(mdu_en), .ent_i(hold_inst_q), .we_o(mdu_we), .ent_o(mdu_ent));
  dispatch_nw_pack #(.N(N)) u_pack_lsq (
    .en_i(lsq_en), .ent_i(hold_inst_q), .we_o(lsq_we), .ent_o(lsq_ent));
  dispatch_nw_pack #(.N(N)) u_pack_rob (
    .en_i(rob_en), .ent_i(hold_inst_q), .we_o(rob_we), .ent_o(rob_ent));

  assign io.dispatch_rdy  = all_go && !flush;
  assign io.alu_rs_we     = alu_we;
  assign io.mdu_rs_we     = mdu_we;
  assign io.lsq_rs_we     = lsq_we;
  assign io.rob_we        = rob_we;
  assign io.alu_rs_entry  = alu_ent;
  assign io.mdu_rs_entry  = mdu_ent;
  assign io.lsq_rs_entry  = lsq_ent;
  assign io.rob_entry     = rob_ent;

  assign stall_alu_cnt = stall_alu_q;
  assign stall_mdu_cnt = stall_mdu_q;
  assign stall_lsq_cnt = stall_lsq_q;
  assign stall_rob_cnt = stall_rob_q;

endmodule

// File: tb/tb_dispatch_nw.sv
// Bench for dispatch_nw: directed scenarios plus random traffic, all checked
// every cycle against a slot-walking reference model of the dispatch rules.
module tb_dispatch_nw;
  import dispatch_nw_pkg::*;

  localparam int N      = 2;
  localparam int FREE_W = $clog2(N + 1);
  localparam int PERF_W = 32;
  localparam int IW     = $bits(renamed_inst_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic [PERF_W-1:0] stall_alu_cnt, stall_mdu_cnt, stall_lsq_cnt, stall_rob_cnt;

  always #5 clk = ~clk;

  dispatch_nw_if #(.N(N), .FREE_W(FREE_W)) io ();

  dispatch_nw #(.DISPATCH_WIDTH(N), .FREE_W(FREE_W), .PERF_W(PERF_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .io            (io),
    .stall_alu_cnt (stall_alu_cnt),
    .stall_mdu_cnt (stall_mdu_cnt),
    .stall_lsq_cnt (stall_lsq_cnt),
    .stall_rob_cnt (stall_rob_cnt)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  renamed_inst_t     m_inst [N];
  bit                m_vld  [N];
  logic [PERF_W-1:0] m_cnt  [4];   // 0 alu, 1 mdu, 2 lsq, 3 rob
  bit                e_go   [N];
  bit                e_all_go;
  int                e_cause;
  logic [IW-1:0]     exp_q [$];
  string             pname [4] = '{"alu", "mdu", "lsq", "rob"};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int tgt_of(input renamed_inst_t x);
    if (x.is_load || x.is_store) return 2;
    if (x.is_muldiv) return 1;
    return 0;
  endfunction

  function automatic int cap(input int v);
    return (v > N) ? N : v;
  endfunction

  function automatic int free_of(input int t);
    case (t)
      0: return cap(int'(io.alu_free));
      1: return cap(int'(io.mdu_free));
      2: return cap(int'(io.lsq_free));
      default: return cap(int'(io.rob_free));
    endcase
  endfunction

  task automatic reset_model();
    for (int i = 0; i < N; i++) begin
      m_inst[i] = '0;
      m_vld[i]  = 1'b0;
    end
    for (int k = 0; k < 4; k++) m_cnt[k] = '0;
  endtask

  // Longest in-order prefix of held instructions that fits the free space.
  task automatic model_eval();
    int used [3];
    int n;
    bit stop;
    used     = '{0, 0, 0};
    n        = 0;
    stop     = 1'b0;
    e_all_go = 1'b1;
    e_cause  = -1;
    for (int i = 0; i < N; i++) begin
      e_go[i] = 1'b0;
      if (m_vld[i]) begin
        if (stop) begin
          e_all_go = 1'b0;
        end else if (n < free_of(3) && used[tgt_of(m_inst[i])] < free_of(tgt_of(m_inst[i]))) begin
          e_go[i] = 1'b1;
          n++;
          used[tgt_of(m_inst[i])]++;
        end else begin
          stop     = 1'b1;
          e_all_go = 1'b0;
          e_cause  = (n >= free_of(3)) ? 3 : tgt_of(m_inst[i]);
        end
      end
    end
  endtask

  task automatic model_commit();
    if (!flush && e_cause >= 0 && m_cnt[e_cause] != '1) m_cnt[e_cause] = m_cnt[e_cause] + 1;
    if (flush) begin
      for (int i = 0; i < N; i++) m_vld[i] = 1'b0;
    end else if (e_all_go) begin
      for (int i = 0; i < N; i++) begin
        if (io.in_valid) begin
          m_inst[i] = io.in_inst[i];
          m_vld[i]  = io.in_inst[i].is_valid;
        end else begin
          m_vld[i] = 1'b0;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) if (e_go[i]) m_vld[i] = 1'b0;
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0]          we_a;
    renamed_inst_t [N-1:0] ent_a;
    logic [N-1:0]          exp_we;
    chk("dispatch_rdy", 64'(io.dispatch_rdy), 64'(e_all_go && !flush));
    for (int p = 0; p < 4; p++) begin
      exp_q.delete();
      if (!flush)
        for (int i = 0; i < N; i++)
          if (m_vld[i] && e_go[i] && (p == 3 || tgt_of(m_inst[i]) == p))
            exp_q.push_back(m_inst[i]);
      case (p)
        0: begin we_a = io.alu_rs_we; ent_a = io.alu_rs_entry; end
        1: begin we_a = io.mdu_rs_we; ent_a = io.mdu_rs_entry; end
        2: begin we_a = io.lsq_rs_we; ent_a = io.lsq_rs_entry; end
        default: begin we_a = io.rob_we; ent_a = io.rob_entry; end
      endcase
      exp_we = '0;
      for (int j = 0; j < exp_q.size(); j++) exp_we[j] = 1'b1;
      chk({pname[p], "_we"}, 64'(we_a), 64'(exp_we));
      for (int j = 0; j < exp_q.size(); j++)
        chk({pname[p], "_entry"}, 64'(ent_a[j]), 64'(exp_q[j]));
    end
    chk("stall_alu_cnt", 64'(stall_alu_cnt), 64'(m_cnt[0]));
    chk("stall_mdu_cnt", 64'(stall_mdu_cnt), 64'(m_cnt[1]));
    chk("stall_lsq_cnt", 64'(stall_lsq_cnt), 64'(m_cnt[2]));
    chk("stall_rob_cnt", 64'(stall_rob_cnt), 64'(m_cnt[3]));
  endtask

  // ---------------- driver tasks ----------------
  function automatic renamed_inst_t mk(input int kind, input int tag);
    renamed_inst_t r;
    r         = '0;
    r.pdst    = 6'(tag);
    r.psrc1   = 6'(tag + 7);
    r.rob_idx = 7'(tag + 3);
    case (kind)
      1: begin r.is_valid = 1'b1; r.is_muldiv = 1'b1; end
      2: begin r.is_valid = 1'b1; r.is_load = 1'b1; end
      3: begin r.is_valid = 1'b0; r.is_muldiv = 1'b1; end
      default: r.is_valid = 1'b1;
    endcase
    return r;
  endfunction

  function automatic renamed_inst_t rand_inst();
    logic [31:0] w;
    renamed_inst_t r;
    w          = $urandom();
    r          = w[IW-1:0];
    r.is_valid = ($urandom_range(0, 7) != 0);
    return r;
  endfunction

  task automatic drive(input bit v, input renamed_inst_t s0, input renamed_inst_t s1,
                       input int af, input int mf, input int lf, input int rf, input bit fl);
    io.in_valid   = v;
    io.in_inst[0] = s0;
    io.in_inst[1] = s1;
    io.alu_free   = FREE_W'(af);
    io.mdu_free   = FREE_W'(mf);
    io.lsq_free   = FREE_W'(lf);
    io.rob_free   = FREE_W'(rf);
    flush         = fl;
  endtask

  task automatic settle();
    #1;
    model_eval();
    check_outputs();
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    renamed_inst_t z;
    z   = '0;
    rst = 1'b1;
    drive(0, z, z, 0, 0, 0, 0, 0);
    reset_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    settle();
    chk("reset_rdy", 64'(io.dispatch_rdy), 64'd1);
    chk("reset_rob_we", 64'(io.rob_we), 64'd0);
    chk("reset_cnt", 64'(stall_alu_cnt), 64'd0);
    advance();

    // Full dispatch, back-to-back
    drive(1, mk(0, 1), mk(1, 2), 2, 2, 2, 2, 0); settle(); advance();
    drive(1, mk(0, 3), mk(1, 4), 2, 2, 2, 2, 0); settle();
    chk("full_alu_we", 64'(io.alu_rs_we), 64'b01);
    chk("full_mdu_we", 64'(io.mdu_rs_we), 64'b01);
    chk("full_rob_we", 64'(io.rob_we), 64'b11);
    chk("full_rdy", 64'(io.dispatch_rdy), 64'd1);
    chk("full_alu_ent0", 64'(io.alu_rs_entry[0]), 64'(mk(0, 1)));
    chk("full_rob_ent1", 64'(io.rob_entry[1]), 64'(mk(1, 2)));
    advance();
    drive(0, z, z, 2, 2, 2, 2, 0); settle();
    chk("full2_alu_ent0", 64'(io.alu_rs_entry[0]), 64'(mk(0, 3)));
    advance();

    // Partial dispatch
    drive(1, mk(0, 5), mk(0, 6), 2, 2, 2, 2, 0); settle(); advance();
    drive(1, mk(2, 7), mk(2, 8), 1, 2, 2, 2, 0); settle();
    chk("part_alu_we", 64'(io.alu_rs_we), 64'b01);
    chk("part_alu_ent0", 64'(io.alu_rs_entry[0]), 64'(mk(0, 5)));
    chk("part_rdy", 64'(io.dispatch_rdy), 64'd0);
    advance();
    drive(0, z, z, 1, 2, 2, 2, 0); settle();
    chk("part_stall_alu", 64'(stall_alu_cnt), 64'd1);
    chk("part2_alu_ent0", 64'(io.alu_rs_entry[0]), 64'(mk(0, 6)));
    chk("part2_rdy", 64'(io.dispatch_rdy), 64'd1);
    advance();

    // In-order blocking behind a stalled MDU op
    drive(1, mk(1, 9), mk(0, 10), 2, 0, 2, 2, 0); settle(); advance();
    drive(0, z, z, 2, 0, 2, 2, 0);
    repeat (3) begin
      settle();
      chk("block_rob_we", 64'(io.rob_we), 64'd0);
      advance();
    end
    drive(0, z, z, 2, 1, 2, 2, 0); settle();
    chk("block_stall_mdu", 64'(stall_mdu_cnt), 64'd3);
    chk("block_mdu_we", 64'(io.mdu_rs_we), 64'b01);
    chk("block_alu_we", 64'(io.alu_rs_we), 64'b01);
    advance();

    // ROB has priority as stall cause
    drive(1, mk(2, 11), mk(2, 12), 2, 2, 2, 2, 0); settle(); advance();
    drive(0, z, z, 2, 2, 0, 0, 0);
    repeat (2) begin settle(); advance(); end
    drive(0, z, z, 2, 2, 2, 2, 0); settle();
    chk("robpri_stall_rob", 64'(stall_rob_cnt), 64'd2);
    chk("robpri_stall_lsq", 64'(stall_lsq_cnt), 64'd0);
    chk("robpri_lsq_we", 64'(io.lsq_rs_we), 64'b11);
    advance();

    // Flush of a half-dispatched group
    drive(1, mk(0, 13), mk(0, 14), 2, 2, 2, 2, 0); settle(); advance();
    drive(1, mk(2, 15), mk(2, 16), 1, 2, 2, 2, 0); settle(); advance();
    drive(1, mk(2, 17), mk(2, 18), 1, 2, 2, 2, 1); settle();
    chk("flush_alu_we", 64'(io.alu_rs_we), 64'd0);
    chk("flush_rob_we", 64'(io.rob_we), 64'd0);
    chk("flush_rdy", 64'(io.dispatch_rdy), 64'd0);
    advance();
    drive(0, z, z, 2, 2, 2, 2, 0); settle();
    chk("postflush_rdy", 64'(io.dispatch_rdy), 64'd1);
    chk("postflush_rob_we", 64'(io.rob_we), 64'd0);
    chk("postflush_stall_alu", 64'(stall_alu_cnt), 64'd2);
    advance();

    // Bubble slot and all-bubble group
    drive(1, mk(3, 19), mk(2, 20), 2, 2, 1, 2, 0); settle(); advance();
    drive(1, mk(3, 21), mk(3, 22), 2, 2, 1, 2, 0); settle();
    chk("bub_lsq_we", 64'(io.lsq_rs_we), 64'b01);
    chk("bub_lsq_ent0", 64'(io.lsq_rs_entry[0]), 64'(mk(2, 20)));
    chk("bub_rob_we", 64'(io.rob_we), 64'b01);
    advance();
    drive(0, z, z, 2, 2, 2, 2, 0); settle();
    chk("allbub_rob_we", 64'(io.rob_we), 64'd0);
    chk("allbub_rdy", 64'(io.dispatch_rdy), 64'd1);
    advance();

    // Asynchronous reset while a group is held
    drive(1, mk(0, 23), mk(0, 24), 2, 2, 2, 2, 0); settle(); advance();
    drive(1, mk(0, 25), mk(0, 26), 0, 2, 2, 2, 0); settle();
    #1 rst = 1'b1;
    #1;
    chk("arst_rob_we", 64'(io.rob_we), 64'd0);
    chk("arst_rdy", 64'(io.dispatch_rdy), 64'd1);
    chk("arst_stall_alu", 64'(stall_alu_cnt), 64'd0);
    reset_model();
    @(negedge clk);
    rst = 1'b0;
    drive(1, mk(0, 27), mk(0, 28), 0, 2, 2, 2, 0); settle(); advance();
    drive(0, z, z, 2, 2, 2, 2, 0); settle();
    chk("arst_reload_alu_we", 64'(io.alu_rs_we), 64'b11);
    advance();

    // Random traffic
    for (int c = 0; c < 500; c++) begin
      drive($urandom_range(0, 3) != 0, rand_inst(), rand_inst(),
            $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 15) == 0);
      settle();
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
